// File: rtl/zet_sram16_ctrl_if.sv
// -----------------------------------------------------------------------------
// zet_sram16_ctrl_if
// Wishbone classic bus between the Zet memory bus master and the 16-bit
// asynchronous SRAM controller.
//   wb_adr_i  word address             (master -> slave)
//   wb_dat_i  write data               (master -> slave)
//   wb_sel_i  byte selects, [0]=low    (master -> slave)
//   wb_we_i   1 = write                (master -> slave)
//   wb_stb_i  strobe                   (master -> slave)
//   wb_cyc_i  cycle                    (master -> slave)
//   wb_dat_o  registered read data     (slave -> master)
//   wb_ack_o  one-cycle acknowledge    (slave -> master)
// Handshake: a request is taken on any clock edge where wb_cyc_i & wb_stb_i
// are high and the slave is idle; exactly one wb_ack_o pulse answers it, and
// the slave ignores stb until that ack cycle has ended.
// -----------------------------------------------------------------------------
interface zet_sram16_ctrl_if #(
  parameter int AW = 18
);
  logic [AW-1:0] wb_adr_i;
  logic [15:0]   wb_dat_i;
  logic [15:0]   wb_dat_o;
  logic [1:0]    wb_sel_i;
  logic          wb_we_i;
  logic          wb_stb_i;
  logic          wb_cyc_i;
  logic          wb_ack_o;

  modport master (
    output wb_adr_i, wb_dat_i, wb_sel_i, wb_we_i, wb_stb_i, wb_cyc_i,
    input  wb_dat_o, wb_ack_o
  );

  modport slave (
    input  wb_adr_i, wb_dat_i, wb_sel_i, wb_we_i, wb_stb_i, wb_cyc_i,
    output wb_dat_o, wb_ack_o
  );
endinterface

// File: rtl/zet_sram16_ctrl.sv
// -----------------------------------------------------------------------------
// zet_sram16_ctrl
// Wishbone classic slave driving an external 256K x 16 asynchronous SRAM.
// Each bus request becomes a timed SRAM read or write sequence; every SRAM
// control pin comes straight from a flop so pin edges are glitch-free.
// Ports:
//   wb_clk_i, wb_rst_i  clock, asynchronous active-high reset
//   wb                  Wishbone slave modport (address, data, sel, we, stb,
//                       cyc in; registered read data and ack out)
//   sram_addr_          SRAM word address
//   sram_data_          SRAM data bus, driven only during the write sequence
//   sram_ce_n_, sram_oe_n_, sram_we_n_  active-low SRAM strobes
//   sram_bw_n_          {UB_,LB_} active-low byte enables
//   dbg_state_o         current FSM state (IDLE=0 RD=1 WSU=2 WP=3 WH=4 DONE=5)
//   dbg_bus_drive_o     1 while the controller drives sram_data_
// Latency from request edge to ack edge: read RD_WAIT, write WR_PULSE+2.
// -----------------------------------------------------------------------------
module zet_sram16_ctrl #(
  parameter int AW       = 18,
  parameter int RD_WAIT  = 2,
  parameter int WR_PULSE = 1
) (
  input  logic            wb_clk_i,
  input  logic            wb_rst_i,
  zet_sram16_ctrl_if.slave wb,
  output logic [AW-1:0]   sram_addr_,
  inout  wire  [15:0]     sram_data_,
  output logic            sram_ce_n_,
  output logic            sram_oe_n_,
  output logic            sram_we_n_,
  output logic [1:0]      sram_bw_n_,
  output logic [2:0]      dbg_state_o,
  output logic            dbg_bus_drive_o
);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_RD   = 3'd1,
    S_WSU  = 3'd2,
    S_WP   = 3'd3,
    S_WH   = 3'd4,
    S_DONE = 3'd5
  } state_t;

  localparam int            CW     = 8;
  localparam logic [CW-1:0] RD_CNT = CW'(RD_WAIT - 1);
  localparam logic [CW-1:0] WP_CNT = CW'(WR_PULSE - 1);

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          ack_q, ack_d;
  logic [15:0]   dat_o_q, dat_o_d;
  logic [AW-1:0] addr_q, addr_d;
  logic          ce_n_q, ce_n_d;
  logic          oe_n_q, oe_n_d;
  logic          we_n_q, we_n_d;
  logic [1:0]    bw_n_q, bw_n_d;
  logic [15:0]   dout_q, dout_d;
  logic          drive_q, drive_d;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    ack_d   = 1'b0;
    dat_o_d = dat_o_q;
    addr_d  = addr_q;
    ce_n_d  = ce_n_q;
    oe_n_d  = oe_n_q;
    we_n_d  = we_n_q;
    bw_n_d  = bw_n_q;
    dout_d  = dout_q;
    drive_d = drive_q;

    case (state_q)
      S_IDLE: begin
        if (wb.wb_cyc_i && wb.wb_stb_i) begin
          addr_d = wb.wb_adr_i;
          ce_n_d = 1'b0;
          if (wb.wb_we_i) begin
            oe_n_d  = 1'b1;
            bw_n_d  = ~wb.wb_sel_i;
            dout_d  = wb.wb_dat_i;
            drive_d = 1'b1;
            state_d = S_WSU;
          end else begin
            // Both lanes are always read; the master picks the byte it wants.
            oe_n_d  = 1'b0;
            bw_n_d  = 2'b00;
            cnt_d   = RD_CNT;
            state_d = S_RD;
          end
        end
      end

      S_RD: begin
        if (cnt_q == '0) begin
          dat_o_d = sram_data_;
          ack_d   = 1'b1;
          ce_n_d  = 1'b1;
          oe_n_d  = 1'b1;
          bw_n_d  = 2'b11;
          state_d = S_DONE;
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end

      // Address and data have had one full cycle of setup; open WE_.
      S_WSU: begin
        we_n_d  = 1'b0;
        cnt_d   = WP_CNT;
        state_d = S_WP;
      end

      S_WP: begin
        if (cnt_q == '0) begin
          we_n_d  = 1'b1;
          state_d = S_WH;
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end

      // Data stays on the bus for one cycle after WE_ rises (hold time).
      S_WH: begin
        drive_d = 1'b0;
        ce_n_d  = 1'b1;
        bw_n_d  = 2'b11;
        ack_d   = 1'b1;
        state_d = S_DONE;
      end

      // Ack cycle: stb is ignored here so one request gives one ack.
      S_DONE: begin
        ce_n_d  = 1'b1;
        oe_n_d  = 1'b1;
        state_d = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      ack_q   <= 1'b0;
      dat_o_q <= '0;
      addr_q  <= '0;
      ce_n_q  <= 1'b1;
      oe_n_q  <= 1'b1;
      we_n_q  <= 1'b1;
      bw_n_q  <= 2'b11;
      dout_q  <= '0;
      drive_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      ack_q   <= ack_d;
      dat_o_q <= dat_o_d;
      addr_q  <= addr_d;
      ce_n_q  <= ce_n_d;
      oe_n_q  <= oe_n_d;
      we_n_q  <= we_n_d;
      bw_n_q  <= bw_n_d;
      dout_q  <= dout_d;
      drive_q <= drive_d;
    end
  end

  assign sram_data_      = drive_q ? dout_q : 16'hzzzz;
  assign wb.wb_dat_o     = dat_o_q;
  assign wb.wb_ack_o     = ack_q;
  assign sram_addr_      = addr_q;
  assign sram_ce_n_      = ce_n_q;
  assign sram_oe_n_      = oe_n_q;
  assign sram_we_n_      = we_n_q;
  assign sram_bw_n_      = bw_n_q;
  assign dbg_state_o     = state_q;
  assign dbg_bus_drive_o = drive_q;

endmodule

// File: tb/tb_zet_sram16_ctrl.sv
`timescale 1ns/1ps
module tb_zet_sram16_ctrl;

  localparam int AW       = 18;
  localparam int RD_WAIT  = 2;
  localparam int WR_PULSE = 1;

  localparam logic [2:0] ST_IDLE = 3'd0;
  localparam logic [2:0] ST_RD   = 3'd1;
  localparam logic [2:0] ST_WSU  = 3'd2;
  localparam logic [2:0] ST_WP   = 3'd3;
  localparam logic [2:0] ST_WH   = 3'd4;
  localparam logic [2:0] ST_DONE = 3'd5;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  // ---------------- DUT with default timing ----------------
  zet_sram16_ctrl_if #(.AW(AW)) wb ();
  wire  [15:0]   sram_data;
  logic [AW-1:0] sram_addr;
  logic          ce_n, oe_n, we_n;
  logic [1:0]    bw_n;
  logic [2:0]    dbg_state;
  logic          drive;

  zet_sram16_ctrl #(.AW(AW), .RD_WAIT(RD_WAIT), .WR_PULSE(WR_PULSE)) dut (
    .wb_clk_i       (clk),
    .wb_rst_i       (rst),
    .wb             (wb),
    .sram_addr_     (sram_addr),
    .sram_data_     (sram_data),
    .sram_ce_n_     (ce_n),
    .sram_oe_n_     (oe_n),
    .sram_we_n_     (we_n),
    .sram_bw_n_     (bw_n),
    .dbg_state_o    (dbg_state),
    .dbg_bus_drive_o(drive)
  );

  // Zero-delay SRAM: drives on read, writes lanes while WE_ is low.
  logic [15:0] mem [0:(1<<AW)-1];
  assign sram_data = (!ce_n && !oe_n && we_n) ? mem[sram_addr] : 16'hzzzz;
  always @(posedge clk) begin
    if (!rst && !ce_n && !we_n) begin
      if (!bw_n[0]) mem[sram_addr][7:0]  <= sram_data[7:0];
      if (!bw_n[1]) mem[sram_addr][15:8] <= sram_data[15:8];
    end
  end

  // ---------------- DUT with RD_WAIT=4 and a 35 ns SRAM ----------------
  zet_sram16_ctrl_if #(.AW(AW)) wb4 ();
  wire  [15:0]   sram_data4;
  logic [AW-1:0] sram_addr4;
  logic          ce_n4, oe_n4, we_n4;
  logic [1:0]    bw_n4;
  logic [2:0]    dbg_state4;
  logic          drive4;

  zet_sram16_ctrl #(.AW(AW), .RD_WAIT(4), .WR_PULSE(1)) dut4 (
    .wb_clk_i       (clk),
    .wb_rst_i       (rst),
    .wb             (wb4),
    .sram_addr_     (sram_addr4),
    .sram_data_     (sram_data4),
    .sram_ce_n_     (ce_n4),
    .sram_oe_n_     (oe_n4),
    .sram_we_n_     (we_n4),
    .sram_bw_n_     (bw_n4),
    .dbg_state_o    (dbg_state4),
    .dbg_bus_drive_o(drive4)
  );

  logic [15:0] mem4 [0:255];
  logic        rd4_ok = 1'b0;
  always @(negedge oe_n4) begin
    rd4_ok = 1'b0;
    #35;
    rd4_ok = 1'b1;
  end
  always @(posedge oe_n4) rd4_ok = 1'b0;
  // Outputs garbage until the access time has elapsed.
  assign sram_data4 = (!ce_n4 && !oe_n4 && we_n4) ?
                      (rd4_ok ? mem4[sram_addr4[7:0]] : 16'h0BAD) : 16'hzzzz;

  // ---------------- scoreboard ----------------
  int n_chk  = 0;
  int n_pass = 0;
  logic [15:0] exp_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h want %h (t=%0t)", name, act, exp, $time);
  endtask

  // ---------------- driver ----------------
  // Issues one request, drops cyc/stb and scrambles address/data right after
  // the request edge, then follows the sequence cycle by cycle until ack.
  task automatic do_req(input logic we, input logic [AW-1:0] adr, input logic [15:0] dat,
                        input logic [1:0] sel, input logic [15:0] exp_rd);
    int k;
    int we_low;
    int oe_low;
    logic got;
    logic [1:0] nsel;
    logic [15:0] exp_d;
    nsel = ~sel;
    @(negedge clk);
    wb.wb_cyc_i = 1'b1;
    wb.wb_stb_i = 1'b1;
    wb.wb_we_i  = we;
    wb.wb_adr_i = adr;
    wb.wb_dat_i = dat;
    wb.wb_sel_i = sel;
    exp_q.push_back(exp_rd);
    @(posedge clk);
    @(negedge clk);
    wb.wb_cyc_i = 1'b0;
    wb.wb_stb_i = 1'b0;
    wb.wb_adr_i = ~adr;
    wb.wb_dat_i = ~dat;
    k = 0; we_low = 0; oe_low = 0; got = 1'b0;
    while (!got && k < 20) begin
      if (!we_n) we_low++;
      if (!oe_n) oe_low++;
      if (drive) check("no_contention_oe_n", oe_n, 1'b1);
      if (we) begin
        if (dbg_state == ST_WSU || dbg_state == ST_WP || dbg_state == ST_WH) begin
          check("wr_addr_stable", sram_addr, adr);
          check("wr_bus_driven", drive, 1'b1);
          check("wr_data_stable", sram_data, dat);
          check("wr_bw_n", bw_n, nsel);
          check("wr_ce_n", ce_n, 1'b0);
        end
      end else begin
        check("rd_no_drive", drive, 1'b0);
        if (dbg_state == ST_RD) begin
          check("rd_addr", sram_addr, adr);
          check("rd_bw_n", bw_n, 2'b00);
          check("rd_ce_n", ce_n, 1'b0);
        end
      end
      if (wb.wb_ack_o) got = 1'b1;
      else begin
        @(negedge clk);
        k++;
      end
    end
    check("ack_seen", got, 1'b1);
    check(we ? "wr_latency" : "rd_latency", k, we ? WR_PULSE + 2 : RD_WAIT);
    if (we) check("we_pulse_cycles", we_low, WR_PULSE);
    else    check("oe_low_cycles", oe_low, RD_WAIT);
    check("done_state", dbg_state, ST_DONE);
    exp_d = exp_q.pop_front();
    check("wb_dat_o", wb.wb_dat_o, exp_d);
    @(negedge clk);
    check("ack_one_cycle", wb.wb_ack_o, 1'b0);
    check("back_to_idle", dbg_state, ST_IDLE);
    check("idle_ce_n", ce_n, 1'b1);
    check("idle_bw_n", bw_n, 2'b11);
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    logic          we;
    logic [AW-1:0] adr;
    logic [15:0]   dat;
    logic [1:0]    sel;
    logic [15:0]   exp_rd;   // wb_dat_o expected after the ack
    logic [15:0]   exp_mem;  // SRAM word expected after the ack
  } vec_t;

  vec_t vecs [10];

  // ---------------- main test ----------------
  initial begin
    int acks;
    int ack_k [2];
    int wide;
    logic prev_ack;
    int k4;
    int oe_low4;
    int drv4;
    logic got4;

    wb.wb_cyc_i = 1'b0; wb.wb_stb_i = 1'b0; wb.wb_we_i = 1'b0;
    wb.wb_adr_i = '0;   wb.wb_dat_i = '0;   wb.wb_sel_i = 2'b00;
    wb4.wb_cyc_i = 1'b0; wb4.wb_stb_i = 1'b0; wb4.wb_we_i = 1'b0;
    wb4.wb_adr_i = '0;   wb4.wb_dat_i = '0;   wb4.wb_sel_i = 2'b00;
    mem4[8'h42] = 16'hC3A5;

    vecs[0] = '{1'b1, 18'h00010, 16'hA55A, 2'b11, 16'h0000, 16'hA55A};
    vecs[1] = '{1'b0, 18'h00010, 16'h0000, 2'b11, 16'hA55A, 16'hA55A};
    vecs[2] = '{1'b1, 18'h00020, 16'hFFFF, 2'b11, 16'hA55A, 16'hFFFF};
    vecs[3] = '{1'b1, 18'h00020, 16'h1234, 2'b01, 16'hA55A, 16'hFF34};
    vecs[4] = '{1'b0, 18'h00020, 16'h0000, 2'b11, 16'hFF34, 16'hFF34};
    vecs[5] = '{1'b1, 18'h00020, 16'hABCD, 2'b10, 16'hFF34, 16'hAB34};
    vecs[6] = '{1'b0, 18'h00020, 16'h0000, 2'b11, 16'hAB34, 16'hAB34};
    vecs[7] = '{1'b1, 18'h00020, 16'h5555, 2'b00, 16'hAB34, 16'hAB34};
    vecs[8] = '{1'b0, 18'h00020, 16'h0000, 2'b11, 16'hAB34, 16'hAB34};
    vecs[9] = '{1'b0, 18'h00010, 16'h0000, 2'b01, 16'hA55A, 16'hA55A};

    // Reset state
    rst = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_state", dbg_state, ST_IDLE);
    check("rst_ack", wb.wb_ack_o, 1'b0);
    check("rst_dat_o", wb.wb_dat_o, 16'h0000);
    check("rst_addr", sram_addr, 18'h0);
    check("rst_ctrl", {ce_n, oe_n, we_n, bw_n}, 5'b11111);
    check("rst_drive", drive, 1'b0);
    rst = 1'b0;

    // Reset in the middle of the WE_ pulse
    @(negedge clk);
    wb.wb_cyc_i = 1'b1; wb.wb_stb_i = 1'b1; wb.wb_we_i = 1'b1;
    wb.wb_adr_i = 18'h00005; wb.wb_dat_i = 16'h5A5A; wb.wb_sel_i = 2'b11;
    @(posedge clk);
    @(negedge clk);
    wb.wb_cyc_i = 1'b0; wb.wb_stb_i = 1'b0;
    @(negedge clk);
    check("pre_rst_in_wp", dbg_state, ST_WP);
    check("pre_rst_we_low", we_n, 1'b0);
    #2 rst = 1'b1;
    #1;
    check("midwp_we_n", we_n, 1'b1);
    check("midwp_ce_n", ce_n, 1'b1);
    check("midwp_bw_n", bw_n, 2'b11);
    check("midwp_drive", drive, 1'b0);
    check("midwp_state", dbg_state, ST_IDLE);
    check("midwp_ack", wb.wb_ack_o, 1'b0);
    check("midwp_dat_o", wb.wb_dat_o, 16'h0000);
    @(negedge clk);
    rst = 1'b0;
    repeat (3) begin
      @(negedge clk);
      check("post_rst_idle", dbg_state, ST_IDLE);
      check("post_rst_quiet", {ce_n, oe_n, we_n, bw_n}, 5'b11111);
    end

    // Table-driven single requests
    for (int i = 0; i < 10; i++) begin
      do_req(vecs[i].we, vecs[i].adr, vecs[i].dat, vecs[i].sel, vecs[i].exp_rd);
      check($sformatf("mem_after_vec%0d", i), mem[vecs[i].adr], vecs[i].exp_mem);
    end

    // Back-to-back writes with stb held high
    @(negedge clk);
    wb.wb_cyc_i = 1'b1; wb.wb_stb_i = 1'b1; wb.wb_we_i = 1'b1;
    wb.wb_adr_i = 18'h3FFFF; wb.wb_dat_i = 16'h1111; wb.wb_sel_i = 2'b11;
    @(posedge clk);
    acks = 0; wide = 0; prev_ack = 1'b0;
    ack_k[0] = -1; ack_k[1] = -1;
    for (int k = 0; k < 16; k++) begin
      @(negedge clk);
      if (k == 0) begin
        wb.wb_adr_i = 18'h00000;
        wb.wb_dat_i = 16'h2222;
      end
      if (wb.wb_ack_o) begin
        if (acks < 2) ack_k[acks] = k;
        acks++;
        if (prev_ack) wide++;
        if (acks == 2) begin
          wb.wb_cyc_i = 1'b0;
          wb.wb_stb_i = 1'b0;
        end
      end
      prev_ack = wb.wb_ack_o;
    end
    check("b2b_ack_count", acks, 2);
    check("b2b_first_ack", ack_k[0], WR_PULSE + 2);
    check("b2b_ack_spacing", ack_k[1] - ack_k[0], WR_PULSE + 4);
    check("b2b_ack_width", wide, 0);
    check("b2b_mem_top", mem[18'h3FFFF], 16'h1111);
    check("b2b_mem_zero", mem[18'h00000], 16'h2222);
    do_req(1'b0, 18'h3FFFF, 16'h0000, 2'b11, 16'h1111);
    do_req(1'b0, 18'h00000, 16'h0000, 2'b11, 16'h2222);

    // Slow SRAM read with RD_WAIT=4
    @(negedge clk);
    wb4.wb_cyc_i = 1'b1; wb4.wb_stb_i = 1'b1; wb4.wb_we_i = 1'b0;
    wb4.wb_adr_i = 18'h00042; wb4.wb_sel_i = 2'b11;
    @(posedge clk);
    @(negedge clk);
    wb4.wb_cyc_i = 1'b0; wb4.wb_stb_i = 1'b0;
    k4 = 0; oe_low4 = 0; drv4 = 0; got4 = 1'b0;
    while (!got4 && k4 < 20) begin
      if (!oe_n4) oe_low4++;
      if (drive4) drv4++;
      if (wb4.wb_ack_o) got4 = 1'b1;
      else begin
        @(negedge clk);
        k4++;
      end
    end
    check("rd4_ack_seen", got4, 1'b1);
    check("rd4_latency", k4, 4);
    check("rd4_oe_low_cycles", oe_low4, 4);
    check("rd4_never_driven", drv4, 0);
    check("rd4_data", wb4.wb_dat_o, 16'hC3A5);
    @(negedge clk);
    check("rd4_ack_one_cycle", wb4.wb_ack_o, 1'b0);
    check("rd4_idle", dbg_state4, ST_IDLE);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, %0d/%0d checks passed", n_pass, n_chk);
    $fatal(1);
  end

endmodule
